// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// The score is latched on LOAD and is only made visible at a frame boundary.
// This keeps a frame from showing digits from two different scores.
// Each digit slot gets one-hot-low anode drive, a hex decode, blink and a decimal point.
// All outputs are active low and registered.
// Optional feature: define BLANK_LEADING_ZEROS_EN to blank leading zero digits 3..1.
module seg7_scan_ctrl #(
    parameter int REFRESH_DIV = 100_000,
    parameter int BLINK_DIV   = 50_000_000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] SCORE_IN,
    input  logic        LOAD,
    input  logic [3:0]  BLINK_MASK,
    input  logic [3:0]  DP_MASK,
    output logic [3:0]  AN,
    output logic [6:0]  C,
    output logic        DP,
    output logic        FRAME_DONE
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [RW-1:0] ref_cnt;
    logic [1:0]    idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [15:0]   active;
    logic [15:0]   pending;
    logic          pend_vld;

    logic          slot_wrap;
    logic          fb;
    logic [3:0]    cur_nibble;
    logic [6:0]    cur_seg;
    logic          lz_blank;
    logic          blank;

    // Segment patterns {g,f,e,d,c,b,a}. The pins are active low, so a 0 bit lights a segment.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign slot_wrap = (ref_cnt == REF_LAST);
    assign fb        = slot_wrap && (idx == 2'd3);

    // Refresh prescaler and digit index. Index 3 wrapping to 0 is the frame boundary.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ref_cnt <= '0;
            idx     <= 2'd0;
        end else if (slot_wrap) begin
            ref_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + RW'(1);
        end
    end

    // Free-running blink timebase. It is independent of the scan position.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // Score double buffer. If several loads arrive in one frame, the last one wins.
    // A load on the boundary cycle goes straight to the display.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            active   <= 16'h0000;
            pending  <= 16'h0000;
            pend_vld <= 1'b0;
        end else if (LOAD && fb) begin
            active   <= SCORE_IN;
            pend_vld <= 1'b0;
        end else if (LOAD) begin
            pending  <= SCORE_IN;
            pend_vld <= 1'b1;
        end else if (fb && pend_vld) begin
            active   <= pending;
            pend_vld <= 1'b0;
        end
    end

    // Select the current nibble, decode it and work out whether this slot is dark.
    always_comb begin
        cur_nibble = active[3:0];
        lz_blank   = 1'b0;
        case (idx)
            2'd0: cur_nibble = active[3:0];
            2'd1: cur_nibble = active[7:4];
            2'd2: cur_nibble = active[11:8];
            default: cur_nibble = active[15:12];
        endcase
`ifdef BLANK_LEADING_ZEROS_EN
        case (idx)
            2'd0: lz_blank = 1'b0;
            2'd1: lz_blank = (active[15:4] == 12'h000);
            2'd2: lz_blank = (active[15:8] == 8'h00);
            default: lz_blank = (active[15:12] == 4'h0);
        endcase
`else
        lz_blank = 1'b0;
`endif
        cur_seg = seg_decode(cur_nibble);
        blank   = (BLINK_MASK[idx] & blink_phase) | lz_blank;
    end

    // Registered pin drive. A blanked slot turns off the anode, the segments and the DP together.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            AN         <= 4'b1111;
            C          <= 7'h7F;
            DP         <= 1'b1;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= fb;
            if (blank) begin
                AN <= 4'b1111;
                C  <= 7'h7F;
                DP <= 1'b1;
            end else begin
                AN <= ~(4'b0001 << idx);
                C  <= cur_seg;
                DP <= ~DP_MASK[idx];
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
// Runs seg7_scan_ctrl with REFRESH_DIV=4 and BLINK_DIV=64.
// Each record in the table is a score plus its expected per-digit pin values.
// Those values are queued when the score is loaded.
// They are popped and compared slot by slot in the frame that shows the score.
module tb_seg7_scan_ctrl;

    localparam int RD = 4;
    localparam int BD = 64;
`ifdef BLANK_LEADING_ZEROS_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] SCORE_IN = 16'h0000;
    logic        LOAD = 1'b0;
    logic [3:0]  BLINK_MASK = 4'b0000;
    logic [3:0]  DP_MASK = 4'b0000;
    logic [3:0]  AN;
    logic [6:0]  C;
    logic        DP;
    logic        FRAME_DONE;

    seg7_scan_ctrl #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .CLK(CLK), .RST_N(RST_N), .SCORE_IN(SCORE_IN), .LOAD(LOAD),
        .BLINK_MASK(BLINK_MASK), .DP_MASK(DP_MASK),
        .AN(AN), .C(C), .DP(DP), .FRAME_DONE(FRAME_DONE)
    );

    // clock / reset-relative edge count
    always #5 CLK = ~CLK;

    int unsigned e;
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) e <= 0;
        else        e <= e + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard: {blink_enable, AN, C, DP}
    logic [12:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    bit seen_ph0 = 1'b0;
    bit seen_ph1 = 1'b0;

    typedef struct packed {
        logic [15:0] score;
        logic [3:0]  bmask;
        logic [3:0]  dmask;
        logic [3:0]  lzb;    // digits that leading-zero blanking darkens
        logic [27:0] segs;   // {c3,c2,c1,c0}
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input vec_t v);
        logic [3:0] an;
        logic [6:0] c;
        logic       dp;
        for (int d = 0; d < 4; d++) begin
            an = ~(4'b0001 << d);
            c  = v.segs[7*d +: 7];
            dp = ~v.dmask[d];
            if (LZ && v.lzb[d]) exp_q.push_back({1'b0, 12'hFFF});
            else                exp_q.push_back({v.bmask[d], an, c, dp});
        end
    endtask

    // driver: one-cycle LOAD strobe, called and returning at a negedge
    task automatic load(input logic [15:0] v);
        SCORE_IN = v;
        LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
    endtask

    task automatic wait_fd(input string name);
        for (int i = 0; i < 40; i++) begin
            if (FRAME_DONE) return;
            @(negedge CLK);
        end
        tests++;
        fails++;
        $display("FAIL %s: FRAME_DONE not seen within 40 cycles", name);
    endtask

    // Call at the negedge where FRAME_DONE is high. Digit d appears 1+4d edges later.
    task automatic check_frame(input string name);
        logic [12:0] item;
        logic [11:0] exp;
        bit ph;
        @(negedge CLK);
        check({name, "_fd_width"}, {15'b0, FRAME_DONE}, 16'h0000);
        for (int d = 0; d < 4; d++) begin
            if (d > 0) repeat (4) @(negedge CLK);
            ph = (((e - 1) / BD) % 2) != 0;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL %s_d%0d: expected queue empty", name, d);
            end else begin
                item = exp_q.pop_front();
                exp  = item[11:0];
                if (item[12]) begin
                    if (ph) seen_ph1 = 1'b1;
                    else    seen_ph0 = 1'b1;
                    if (ph) exp = 12'hFFF;
                end
                check($sformatf("%s_d%0d", name, d), {4'h0, AN, C, DP}, {4'h0, exp});
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        DP_MASK    = v.dmask;
        BLINK_MASK = v.bmask;
        load(v.score);
        push_frame(v);
        wait_fd(name);
        check_frame(name);
    endtask

    initial begin
        tbl[0] = '{16'h1234, 4'b0000, 4'b0000, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}};
        tbl[1] = '{16'h9ABC, 4'b0000, 4'b0001, 4'b0000, {7'h10, 7'h08, 7'h03, 7'h46}};
        tbl[2] = '{16'hDEF0, 4'b0000, 4'b1010, 4'b0000, {7'h21, 7'h06, 7'h0E, 7'h40}};
        tbl[3] = '{16'h0042, 4'b0000, 4'b0100, 4'b1100, {7'h40, 7'h40, 7'h19, 7'h24}};
        tbl[4] = '{16'h5678, 4'b1000, 4'b0000, 4'b0000, {7'h12, 7'h02, 7'h78, 7'h00}};
        tbl[5] = '{16'h0000, 4'b0000, 4'b0000, 4'b1110, {7'h40, 7'h40, 7'h40, 7'h40}};

        // reset held
        repeat (3) @(negedge CLK);
        check("rst_an", {12'h0, AN}, 16'h000F);
        check("rst_c", {9'h0, C}, 16'h007F);
        check("rst_dp_fd", {14'h0, DP, FRAME_DONE}, 16'h0002);
        RST_N = 1'b1;

        // first slot after release shows digit0 of zero
        @(negedge CLK);
        check("rel_slot0", {4'h0, AN, C, DP}, {4'h0, 4'b1110, 7'h40, 1'b1});
        check("rel_fd", {15'h0, FRAME_DONE}, 16'h0000);

        // load mid-frame: display must not change before the boundary
        load(tbl[0].score);
        check("load_no_tear", {4'h0, AN, C, DP}, {4'h0, 4'b1110, 7'h40, 1'b1});
        push_frame(tbl[0]);
        wait_fd("v1234");
        check("fd_at_16", e[15:0], 16'd16);
        check_frame("v1234");

        // table vectors
        for (int i = 1; i < 4; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // two loads in one frame: last wins
        DP_MASK = 4'b0000;
        BLINK_MASK = 4'b0000;
        load(16'h1111);
        load(16'h2222);
        push_frame('{16'h2222, 4'b0000, 4'b0000, 4'b0000, {7'h24, 7'h24, 7'h24, 7'h24}});
        wait_fd("last_wins");
        check_frame("last_wins");

        // load on the boundary cycle itself (idle cycles until ref_cnt=3, idx=3)
        while ((e % 16) != 15) @(negedge CLK);
        load(16'h3333);
        check("bypass_fd", {15'h0, FRAME_DONE}, 16'h0001);
        push_frame('{16'h3333, 4'b0000, 4'b0000, 4'b0000, {7'h30, 7'h30, 7'h30, 7'h30}});
        wait_fd("bypass");
        check_frame("bypass");

        // blink on digit3 across both blink phases
        DP_MASK = tbl[4].dmask;
        BLINK_MASK = tbl[4].bmask;
        load(tbl[4].score);
        for (int f = 0; f < 8; f++) begin
            push_frame(tbl[4]);
            wait_fd($sformatf("blink_f%0d", f));
            check_frame($sformatf("blink_f%0d", f));
        end
        check("blink_phases", {14'h0, seen_ph1, seen_ph0}, 16'h0003);
        BLINK_MASK = 4'b0000;

        // reset dropped during the digit2 slot
        wait_fd("pre_rst");
        repeat (9) @(negedge CLK);
        check("pre_rst_d2", {4'h0, AN, C, DP}, {4'h0, 4'b1011, 7'h02, 1'b1});
        #1 RST_N = 1'b0;
        #1;
        check("rst_mid_an", {12'h0, AN}, 16'h000F);
        check("rst_mid_c_dp_fd", {7'h0, C, DP, FRAME_DONE}, {7'h0, 7'h7F, 1'b1, 1'b0});
        exp_q.delete();
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("rerel_slot0", {4'h0, AN, C, DP}, {4'h0, 4'b1110, 7'h40, 1'b1});
        push_frame(tbl[5]);
        wait_fd("zero");
        check("rerel_fd_at_16", e[15:0], 16'd16);
        check_frame("zero");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
